// File: rtl/multi_div.sv
// multi_div: restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, reset (sync, active-high), start, dividend, divisor in;
//   busy, done, quotient, remainder, div_zero out.
// Optional: define MULTI_DIV_SIGNED_EN for two's-complement operands.
module multi_div #(
    parameter  int S = 3,
    localparam int W = 2**S
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [W-1:0] ONE = 1;

    state_t         state_q, state_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [S-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rmd_q, rmd_d;
    logic           dz_q, dz_d;

    logic [W+1:0]   shifted, diff;
    logic           qbit;
    logic [W:0]     rem_nx;
    logic [W-1:0]   acc_nx;
    logic [W-1:0]   dvd_mag, dvs_mag;
    logic [W-1:0]   quo_fix, rmd_fix;

    // acc holds the not-yet-consumed dividend bits in its upper part
    // and collects quotient bits from the bottom.
    assign shifted = {rem_q, acc_q[W-1]};
    assign diff    = shifted - {2'b00, dvs_q};
    assign qbit    = ~diff[W+1];
    assign rem_nx  = qbit ? diff[W:0] : shifted[W:0];
    assign acc_nx  = {acc_q[W-2:0], qbit};

`ifdef MULTI_DIV_SIGNED_EN
    logic nq_q, nq_d;
    logic nr_q, nr_d;

    assign dvd_mag = dividend[W-1] ? (~dividend) + ONE : dividend;
    assign dvs_mag = divisor[W-1]  ? (~divisor) + ONE  : divisor;
    // Quotient truncates toward zero; remainder follows the dividend.
    assign quo_fix = nq_q ? (~acc_nx) + ONE : acc_nx;
    assign rmd_fix = nr_q ? (~rem_nx[W-1:0]) + ONE : rem_nx[W-1:0];

    always_comb begin
        nq_d = nq_q;
        nr_d = nr_q;
        if (state_q != RUN && start) begin
            nq_d = dividend[W-1] ^ divisor[W-1];
            nr_d = dividend[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nq_q <= 1'b0;
            nr_q <= 1'b0;
        end else begin
            nq_q <= nq_d;
            nr_q <= nr_d;
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign quo_fix = acc_nx;
    assign rmd_fix = rem_nx[W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dz_d  = 1'b0;
                    rem_d = '0;
                    acc_d = dvd_mag;
                    dvs_d = dvs_mag;
                    cnt_d = S'(W-1);
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                acc_d = acc_nx;
                cnt_d = cnt_q - S'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = quo_fix;
                    rmd_d   = rmd_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_multi_div.sv
// tb_multi_div: randomized self-checking bench for multi_div (S=3).
// Build with MULTI_DIV_SIGNED_EN to exercise the signed variant.
module tb_multi_div;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int errors = 0;
    int checks = 0;

    multi_div #(.S(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r);
`ifdef MULTI_DIV_SIGNED_EN
        int sa, sb, qi, ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        qi = sa / sb;
        ri = sa % sb;
        q  = qi[7:0];
        r  = ri[7:0];
`else
        q = a / b;
        r = a % b;
`endif
    endfunction

    // Issue one operation; report the cycle done rose (-1 on timeout)
    // and how many cycles busy was seen high before that.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int dcyc, output int bcyc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
        dcyc  = -1;
        bcyc  = 0;
        for (int c = 1; c <= 30; c++) begin
            if (busy) bcyc++;
            if (done) begin
                dcyc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        tick();
        tick();
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {busy, done, div_zero});
        end
        checks++;
        if ({quotient, remainder} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_results got %h want 0000", {quotient, remainder});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d, b;
        run_op(8'd200, 8'd7, d, b);
        checks++;
        if (d !== 9) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d want 9", d);
        end
        checks++;
        if (b !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 8", b);
        end
        checks++;
        if ({quotient, remainder, div_zero} !== {8'd28, 8'd4, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b want q=28 r=4 dz=0",
                     quotient, remainder, div_zero);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_div_zero();
        int d, b;
        run_op(8'd5, 8'd0, d, b);
        checks++;
        if (d !== 1 || b !== 0) begin
            errors++;
            $display("FAIL divzero_timing got done@%0d busy=%0d want done@1 busy=0", d, b);
        end
        checks++;
        if ({quotient, remainder, div_zero} !== {8'hFF, 8'd5, 1'b1}) begin
            errors++;
            $display("FAIL divzero_result got q=%h r=%h dz=%b want q=ff r=05 dz=1",
                     quotient, remainder, div_zero);
        end
        tick();
        checks++;
        if ({done, div_zero, quotient} !== {1'b0, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL divzero_hold got done=%b dz=%b q=%h want 0 1 ff",
                     done, div_zero, quotient);
        end
    endtask

    task automatic test_ignore_start();
        int dcyc;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        tick();
        start = 1'b0;
        dcyc  = -1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (dcyc !== 9 || quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++;
            $display("FAIL ignore_result got done@%0d q=%0d r=%0d want done@9 q=28 r=4",
                     dcyc, quotient, remainder);
        end
        // New start while in DONE is taken immediately.
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || quotient !== 8'd28) begin
            errors++;
            $display("FAIL done_restart got busy=%b q=%0d want busy=1 q=28", busy, quotient);
        end
        dcyc = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (dcyc !== 9 || quotient !== 8'd3 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL restart_result got done@%0d q=%0d r=%0d want done@9 q=3 r=0",
                     dcyc, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int seen, d, b;
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 8'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, div_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles want 0", seen);
        end
        run_op(8'd255, 8'd1, d, b);
        checks++;
        if (d !== 9 || quotient !== 8'd255 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL abort_rerun got done@%0d q=%0d r=%0d want done@9 q=255 r=0",
                     d, quotient, remainder);
        end
        tick();
    endtask

`ifdef MULTI_DIV_SIGNED_EN
    task automatic test_signed();
        logic [7:0] va [3] = '{8'hF9, 8'h80, 8'h07};
        logic [7:0] vb [3] = '{8'h02, 8'hFF, 8'hFE};
        logic [7:0] eq [3] = '{8'hFD, 8'h80, 8'hFD};
        logic [7:0] er [3] = '{8'hFF, 8'h00, 8'h01};
        int d, b;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], d, b);
            checks++;
            if (d !== 9 || quotient !== eq[i] || remainder !== er[i]) begin
                errors++;
                $display("FAIL signed_%0d got done@%0d q=%h r=%h want done@9 q=%h r=%h",
                         i, d, quotient, remainder, eq[i], er[i]);
            end
            tick();
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] a [21];
        logic [7:0] b [21];
        logic [7:0] eq, er;
        int period;
        for (int i = 0; i < 21; i++) begin
            a[i] = 8'($urandom);
            b[i] = 8'($urandom_range(1, 255));
            if (i % 5 == 1) b[i] = 8'($urandom_range(1, 15));
        end
        start    = 1'b1;
        dividend = a[0];
        divisor  = b[0];
        tick();
        for (int k = 0; k < 20; k++) begin
            // Operands of the next op sit on the bus during RUN and must
            // not disturb the current one.
            dividend = a[k+1];
            divisor  = b[k+1];
            start    = 1'b1;
            period   = -1;
            for (int c = 1; c <= 30; c++) begin
                if (done) begin
                    period = c;
                    break;
                end
                tick();
            end
            ref_div(a[k], b[k], eq, er);
            checks++;
            if (period !== 9 || quotient !== eq || remainder !== er || div_zero !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d %h/%h got period=%0d q=%h r=%h dz=%b want 9 q=%h r=%h dz=0",
                         k, a[k], b[k], period, quotient, remainder, div_zero, eq, er);
            end
            if (k == 19) start = 1'b0;
            tick();
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
`ifndef MULTI_DIV_SIGNED_EN
        test_basic();
        test_ignore_start();
        test_reset_abort();
`else
        test_signed();
`endif
        test_div_zero();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
